// File: rtl/data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_lsu                                                 |
// | Description : Single-port data memory with an RV32I load/store front end.  |
// |               Accepts one request at a time and inserts WAIT wait states.  |
// |               Responses carry sign/zero-extended load data and a fault     |
// |               flag for misaligned, illegal or out-of-range accesses.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_lsu #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int WAIT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
);

   localparam int         c_AW        = $clog2(DEPTH);
   localparam logic [2:0] c_WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_cnt;
   logic [2:0]       w_cnt_nxt;
   logic             w_accept;
   logic             w_enter_resp;
   logic             w_commit;

   logic             r_we;
   logic [2:0]       r_funct3;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;

   logic             w_we;
   logic [2:0]       w_funct3;
   logic [WIDTH-1:0] w_addr;
   logic [WIDTH-1:0] w_wdata;

   logic             w_err;
   logic [c_AW-1:0]  w_idx;
   logic [1:0]       w_lane;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_load;
   logic [WIDTH-1:0] w_wlane;
   logic [3:0]       w_be;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   assign w_accept     = req_valid && (r_state == S_IDLE);
   assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);
   // With zero wait states the access happens on the accept edge itself, so
   // the live request fields are used while IDLE, the captured copy otherwise.
   assign w_we         = (r_state == S_IDLE) ? req_we     : r_we;
   assign w_funct3     = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_addr       = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_wdata      = (r_state == S_IDLE) ? req_wdata  : r_wdata;
   assign w_commit     = w_enter_resp && w_we && !w_err && rst_n;

   assign w_idx   = w_addr[c_AW+1:2];
   assign w_lane  = w_addr[1:0];
   assign w_shift = r_mem[w_idx] >> {w_lane, 3'b000};

   // State and wait counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (WAIT > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = c_WAIT_LOAD;
               end else begin
                  w_state_nxt = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 3'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Fault decode: bad size code, misalignment, unsigned store, out of range.
   always_comb begin
      w_err = 1'b0;
      case (w_funct3)
         3'b000:  w_err = 1'b0;
         3'b001:  w_err = w_addr[0];
         3'b010:  w_err = |w_addr[1:0];
         3'b100:  w_err = w_we;
         3'b101:  w_err = w_we | w_addr[0];
         default: w_err = 1'b1;
      endcase
      if ((w_addr >> (c_AW + 2)) != '0) begin
         w_err = 1'b1;
      end
   end

   // Load alignment and extension; the selected lane is already at bit 0.
   always_comb begin
      case (w_funct3)
         3'b000:  w_load = {{(WIDTH-8){w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_load = {{(WIDTH-16){w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_shift[7:0]};
         3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

   // Store lane replication and byte enables.
   always_comb begin
      w_wlane = w_wdata;
      w_be    = 4'b0000;
      case (w_funct3)
         3'b000: begin
            w_wlane = {4{w_wdata[7:0]}};
            w_be    = 4'b0001 << w_lane;
         end
         3'b001: begin
            w_wlane = {2{w_wdata[15:0]}};
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
         end
         3'b010:  w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // Request capture at accept; response capture on the edge entering RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
         if (w_enter_resp) begin
            r_rdata <= (w_we || w_err) ? '0 : w_load;
            r_err   <= w_err;
         end
      end
   end

   // Byte-enabled memory write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits; only 32 is supported.
REQ-002 Parameter DEPTH, default 64, number of WIDTH-bit words; power of two, 4..4096.
REQ-003 Parameter WAIT, default 1, wait-state cycles between accept and response; 0..7.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  WIDTH  byte address.
REQ-011 req_wdata  input  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  WIDTH  load result, extended per funct3; 0 for stores and errors.
REQ-015 rsp_err  output  1  request faulted; valid only with rsp_valid.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid && req_ready at a rising edge; block SHALL register we, funct3, addr, wdata at accept.
REQ-018 IDLE -> WAIT on accept if WAIT>0, else IDLE -> RESP; WAIT counter SHALL load WAIT-1, decrement each cycle, WAIT -> RESP when counter is 0.
REQ-019 Memory access (read capture and write commit) SHALL occur on the edge entering RESP; rsp_valid SHALL be 1 exactly in RESP, so response first appears WAIT+1 cycles after accept.
REQ-020 RESP -> IDLE when rsp_ready=1; rsp_valid, rsp_rdata, rsp_err SHALL hold stable while rsp_ready=0.
REQ-021 No new request SHALL be accepted in the cycle RESP exits; next accept earliest the following cycle.
REQ-022 Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
REQ-023 Stores SHALL write only addressed bytes: B one lane, H lanes {addr[1],0}..+1, W all four; other bytes unchanged.
REQ-024 Loads SHALL shift addressed lane(s) to bit 0; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-025 rsp_err=1 if: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}; addr[WIDTH-1:log2(DEPTH)+2] != 0.
REQ-026 Faulted request SHALL NOT modify memory and SHALL return rsp_rdata=0; its timing is identical to a normal request.
REQ-027 Memory contents SHALL NOT depend on reset; uninitialised reads return X in simulation.
REQ-028 Memory SHALL be a single array of DEPTH words, inferable as distributed RAM with byte write enables.

Reset
REQ-029 rst_n=0 SHALL force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately, independent of clk.
REQ-030 Reset during WAIT SHALL discard the pending request; a pending store SHALL NOT commit.
REQ-031 Reset during RESP SHALL drop the response; the store already committed remains.
REQ-032 First accept possible at the first rising edge with rst_n=1.

Verification (WAIT=1, DEPTH=64)
REQ-033 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> each rsp_valid 2 cycles after accept, load rdata 0xDEADBEEF, err 0.
REQ-034 After REQ-033: sb 0x12 data 0x80; lb 0x12 -> 0xFFFFFF80; lbu 0x12 -> 0x00000080; lw 0x10 -> 0xDE80BEEF.
REQ-035 lh 0x11, sw 0x13, funct3 011, sb 0x100 -> each err 1, rdata 0; lw 0x10 afterward still 0xDE80BEEF.
REQ-036 lw with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable all 5 cycles, req_ready 0 throughout; IDLE on the cycle after rsp_ready=1.
REQ-037 sw 0x20 data 0x12345678, rst_n pulsed low in WAIT -> rsp_valid 0 immediately, req_ready 1; later lw 0x20 returns prior contents, not 0x12345678.
REQ-038 Repeat REQ-033 with WAIT=0 and WAIT=7 -> response latency 1 and 8 cycles respectively.
